// File: rtl/fp32_max_min_tracker.sv
// Per-frame running max/min tracker for an FP32 stream, with NaN accounting
// and a saturating element count, presented on a registered output handshake.
module fp32_max_min_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_nan_seen,
    output logic                  out_all_nan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CANON_NAN = 32'h7FC0_0000;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic [DATA_WIDTH-1:0]   min_q, min_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    nan_q, nan_d;
    logic                    have_num_q, have_num_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_max_q, out_max_d;
    logic [DATA_WIDTH-1:0]   out_min_q, out_min_d;
    logic [CNT_WIDTH-1:0]    out_count_q, out_count_d;
    logic                    out_nan_seen_q, out_nan_seen_d;
    logic                    out_all_nan_q, out_all_nan_d;

    logic                    in_xfer;
    logic                    is_nan;
    logic                    frame_start;
    logic [CNT_WIDTH-1:0]    base_cnt;
    logic                    base_nan;
    logic                    base_have;
    logic [DATA_WIDTH-1:0]   new_key, max_key, min_key;
    logic [DATA_WIDTH-1:0]   nxt_max, nxt_min;
    logic [CNT_WIDTH-1:0]    nxt_cnt;
    logic                    nxt_nan, nxt_have;

    // Both zero encodings share one key so +0/-0 tie and the first one seen is kept.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] w);
        if (w[DATA_WIDTH-2:0] == '0)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else if (!w[DATA_WIDTH-1])
            return {1'b1, w[DATA_WIDTH-2:0]};
        else
            return ~w;
    endfunction

    assign in_ready = !rst && (state_q != HOLD);
    assign in_xfer  = in_valid && in_ready;
    assign is_nan   = (in_data[30:23] == 8'hFF) && (in_data[22:0] != '0);

    always_comb begin
        frame_start = (state_q == IDLE);
        base_cnt    = frame_start ? '0 : cnt_q;
        base_nan    = frame_start ? 1'b0 : nan_q;
        base_have   = frame_start ? 1'b0 : have_num_q;

        new_key = order_key(in_data);
        max_key = order_key(max_q);
        min_key = order_key(min_q);

        nxt_max = max_q;
        nxt_min = min_q;
        if (!is_nan) begin
            if (!base_have) begin
                nxt_max = in_data;
                nxt_min = in_data;
            end else begin
                if (new_key > max_key) nxt_max = in_data;
                if (new_key < min_key) nxt_min = in_data;
            end
        end
        nxt_cnt  = (base_cnt == '1) ? base_cnt : base_cnt + 1'b1;
        nxt_nan  = base_nan | is_nan;
        nxt_have = base_have | !is_nan;
    end

    always_comb begin
        state_d        = state_q;
        max_d          = max_q;
        min_d          = min_q;
        cnt_d          = cnt_q;
        nan_d          = nan_q;
        have_num_d     = have_num_q;
        out_valid_d    = out_valid_q;
        out_max_d      = out_max_q;
        out_min_d      = out_min_q;
        out_count_d    = out_count_q;
        out_nan_seen_d = out_nan_seen_q;
        out_all_nan_d  = out_all_nan_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (in_xfer) begin
                    max_d      = nxt_max;
                    min_d      = nxt_min;
                    cnt_d      = nxt_cnt;
                    nan_d      = nxt_nan;
                    have_num_d = nxt_have;
                    if (in_last) begin
                        state_d        = HOLD;
                        out_valid_d    = 1'b1;
                        out_max_d      = nxt_have ? nxt_max : CANON_NAN;
                        out_min_d      = nxt_have ? nxt_min : CANON_NAN;
                        out_count_d    = nxt_cnt;
                        out_nan_seen_d = nxt_nan;
                        out_all_nan_d  = !nxt_have;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            max_q          <= '0;
            min_q          <= '0;
            cnt_q          <= '0;
            nan_q          <= 1'b0;
            have_num_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_max_q      <= '0;
            out_min_q      <= '0;
            out_count_q    <= '0;
            out_nan_seen_q <= 1'b0;
            out_all_nan_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            max_q          <= max_d;
            min_q          <= min_d;
            cnt_q          <= cnt_d;
            nan_q          <= nan_d;
            have_num_q     <= have_num_d;
            out_valid_q    <= out_valid_d;
            out_max_q      <= out_max_d;
            out_min_q      <= out_min_d;
            out_count_q    <= out_count_d;
            out_nan_seen_q <= out_nan_seen_d;
            out_all_nan_q  <= out_all_nan_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_max      = out_max_q;
    assign out_min      = out_min_q;
    assign out_count    = out_count_q;
    assign out_nan_seen = out_nan_seen_q;
    assign out_all_nan  = out_all_nan_q;

endmodule

// File: tb/tb_fp32_max_min_tracker.sv
// Directed bench for fp32_max_min_tracker: table-driven frames plus hand-written
// backpressure, mid-frame reset and counter saturation sequences.
module tb_fp32_max_min_tracker;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_max;
    logic [31:0]   out_min;
    logic [CW-1:0] out_count;
    logic          out_nan_seen;
    logic          out_all_nan;

    int n_checks = 0;
    int n_fails  = 0;

    fp32_max_min_tracker #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_min(out_min), .out_count(out_count),
        .out_nan_seen(out_nan_seen), .out_all_nan(out_all_nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [3:0][31:0] w;
        logic [31:0]     e_max;
        logic [31:0]     e_min;
        int              e_cnt;
        logic            e_nan;
        logic            e_all;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] buf_w[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive buf_w[0..n-1] as one frame, then check the result and hand it off
    // after holding out_ready low for 'hold' cycles.
    task automatic run_frame(input int n, input int hold, input logic [31:0] e_max,
                             input logic [31:0] e_min, input int e_cnt,
                             input logic e_nan, input logic e_all);
        int bound;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = buf_w[i];
            in_last  = (i == n - 1);
            bound    = 0;
            while (!in_ready && bound < 20) begin
                @(negedge clk);
                bound++;
            end
            if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("out_max", out_max, e_max);
        chk("out_min", out_min, e_min);
        chk("out_count", 32'(out_count), 32'(e_cnt));
        chk("out_nan_seen", 32'(out_nan_seen), 32'(e_nan));
        chk("out_all_nan", 32'(out_all_nan), 32'(e_all));
        for (int h = 0; h < hold; h++) begin
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_max", out_max, e_max);
            chk("hold_out_min", out_min, e_min);
            chk("hold_out_count", 32'(out_count), 32'(e_cnt));
        end
        chk("exit_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_out_valid", 32'(out_valid), 32'd0);
        chk("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{3, {32'h0, 32'h40E00000, 32'h3F800000, 32'h40400000},
                    32'h40E00000, 32'h3F800000, 3, 1'b0, 1'b0};
        vecs[1] = '{4, {32'h00000001, 32'hFF800000, 32'h7F800000, 32'hC0000000},
                    32'h7F800000, 32'hFF800000, 4, 1'b0, 1'b0};
        vecs[2] = '{2, {32'h0, 32'h0, 32'h00000000, 32'h80000000},
                    32'h80000000, 32'h80000000, 2, 1'b0, 1'b0};
        vecs[3] = '{3, {32'h0, 32'hFFC00001, 32'h40A00000, 32'h7FC00000},
                    32'h40A00000, 32'h40A00000, 3, 1'b1, 1'b0};
        vecs[4] = '{1, {32'h0, 32'h0, 32'h0, 32'h7FC00000},
                    32'h7FC00000, 32'h7FC00000, 1, 1'b1, 1'b1};
        vecs[5] = '{2, {32'h0, 32'h0, 32'hC0400000, 32'hBF800000},
                    32'hBF800000, 32'hC0400000, 2, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_max", out_max, 32'h0);
        chk("reset_out_min", out_min, 32'h0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        chk("reset_flags", {30'd0, out_nan_seen, out_all_nan}, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) buf_w[i] = vecs[v].w[i];
            run_frame(vecs[v].n, 0, vecs[v].e_max, vecs[v].e_min, vecs[v].e_cnt,
                      vecs[v].e_nan, vecs[v].e_all);
        end

        // Backpressure: positive-integer frame held for 5 cycles.
        for (int i = 0; i < vecs[0].n; i++) buf_w[i] = vecs[0].w[i];
        run_frame(3, 5, 32'h40E00000, 32'h3F800000, 3, 1'b0, 1'b0);

        // Reset mid-frame after two accepted words.
        @(negedge clk);
        in_valid = 1'b1; in_last = 1'b0; in_data = 32'h42000000;
        @(negedge clk);
        in_data = 32'hC2000000;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        buf_w[0] = 32'h3F800000;
        run_frame(1, 0, 32'h3F800000, 32'h3F800000, 1, 1'b0, 1'b0);

        // Counter saturation with a 4-bit counter: 20 words report 15.
        for (int i = 0; i < 20; i++) buf_w[i] = 32'h40000000 + 32'(i);
        run_frame(20, 0, 32'h40000013, 32'h40000000, 15, 1'b0, 1'b0);

        // Next frame after saturation starts its count afresh.
        buf_w[0] = 32'hBF800000;
        buf_w[1] = 32'h7FC00000;
        run_frame(2, 0, 32'hBF800000, 32'hBF800000, 2, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
